// File: rtl/muldiv_sequencer.sv
// Iterative signed multiply/divide unit for the multicycle CPU's mult/div instructions.
// Runs a WIDTH-cycle shift-add multiply or restoring divide on magnitudes, then sign-fixes into HI/LO.
module muldiv_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_mult,
    input  logic             start_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] MULT = 3'd1;
    localparam logic [2:0] DIV  = 3'd2;
    localparam logic [2:0] FIX  = 3'd3;
    localparam logic [2:0] DONE = 3'd4;

    logic [2:0]       state;
    logic [CNT_W-1:0] cnt;
    logic             sign_a;
    logic             sign_b;
    logic             op_div;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;
    logic [WIDTH-1:0] acc_p;
    logic [WIDTH-1:0] acc_q;

    function automatic logic [WIDTH-1:0] negate_w(input logic [WIDTH-1:0] v, input logic en);
        return en ? -v : v;
    endfunction

    function automatic logic [2*WIDTH-1:0] negate_2w(input logic [2*WIDTH-1:0] v, input logic en);
        return en ? -v : v;
    endfunction

    // Two's-complement magnitude; the most negative value maps to 2^(WIDTH-1) unsigned.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? -v : v;
    endfunction

    logic accept;
    logic take_mult;
    logic take_div;
    logic zero_div;

    assign accept    = (state == IDLE) || (state == DONE);
    assign take_mult = accept && start_mult;
    assign take_div  = accept && !start_mult && start_div;
    assign zero_div  = take_div && (b == '0);

    logic [WIDTH:0]       mul_sum;
    logic [WIDTH:0]       div_shift;
    logic [WIDTH:0]       div_trial;
    logic [2*WIDTH-1:0]   product;

    assign mul_sum   = {1'b0, acc_p} + (acc_q[0] ? {1'b0, mag_a} : '0);
    // Remainder stays below |b| <= 2^(WIDTH-1), so the shifted value fits WIDTH bits and
    // bit WIDTH of the trial difference is a valid borrow.
    assign div_shift = {acc_p, acc_q[WIDTH-1]};
    assign div_trial = div_shift - {1'b0, mag_b};
    assign product   = negate_2w({acc_p, acc_q}, sign_a ^ sign_b);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            sign_a   <= 1'b0;
            sign_b   <= 1'b0;
            op_div   <= 1'b0;
            mag_a    <= '0;
            mag_b    <= '0;
            acc_p    <= '0;
            acc_q    <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            div_zero <= 1'b0;
            hi       <= '0;
            lo       <= '0;
        end else begin
            done     <= 1'b0;
            div_zero <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    state <= IDLE;
                    if (zero_div) begin
                        div_zero <= 1'b1;
                    end else if (take_mult || take_div) begin
                        sign_a <= a[WIDTH-1];
                        sign_b <= b[WIDTH-1];
                        mag_a  <= magnitude(a);
                        mag_b  <= magnitude(b);
                        op_div <= take_div;
                        cnt    <= CNT_W'(WIDTH - 1);
                        busy   <= 1'b1;
                        acc_p  <= '0;
                        acc_q  <= take_div ? magnitude(a) : magnitude(b);
                        state  <= take_div ? DIV : MULT;
                    end
                end
                MULT: begin
                    acc_p <= mul_sum[WIDTH:1];
                    acc_q <= {mul_sum[0], acc_q[WIDTH-1:1]};
                    if (cnt == '0) state <= FIX;
                    else           cnt   <= cnt - CNT_W'(1);
                end
                DIV: begin
                    if (!div_trial[WIDTH]) begin
                        acc_p <= div_trial[WIDTH-1:0];
                        acc_q <= {acc_q[WIDTH-2:0], 1'b1};
                    end else begin
                        acc_p <= div_shift[WIDTH-1:0];
                        acc_q <= {acc_q[WIDTH-2:0], 1'b0};
                    end
                    if (cnt == '0) state <= FIX;
                    else           cnt   <= cnt - CNT_W'(1);
                end
                FIX: begin
                    if (op_div) begin
                        lo <= negate_w(acc_q, sign_a ^ sign_b);
                        hi <= negate_w(acc_p, sign_a);
                    end else begin
                        hi <= product[2*WIDTH-1:WIDTH];
                        lo <= product[WIDTH-1:0];
                    end
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= DONE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
